// File: rtl/cgra_im_loader_pkg.sv
// Shared types and header layout for the CGRA instruction-memory loader.
// IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word per block.
package cgra_im_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA_LO,
        S_DATA_HI,
`ifdef IM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = 8;
    localparam int COUNT_LSB  = 16;

    // Bits of an immediate instruction carried by its second stream word.
    function automatic int immHiWidth(input int immWidth, input int dWidth);
        return immWidth - dWidth;
    endfunction

endpackage

// File: rtl/cgra_im_loader_if.sv
// Host word stream plus shared instruction-memory write bus.
// The slave modport is the loader; master is the host/memory side.
interface cgra_im_loader_if #(
    parameter int D_WIDTH           = 32,
    parameter int I_WIDTH           = 12,
    parameter int I_IMM_WIDTH       = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 10,
    parameter int NUM_IMM           = 3
);
    logic [D_WIDTH-1:0]           iS_Data;
    logic                         iS_Valid;
    logic                         oS_Ready;
    logic [NUM_ID+NUM_IMM-1:0]    oIM_WriteEnable;
    logic [IM_MEM_ADDR_WIDTH-1:0] oIM_WriteAddress;
    logic [I_WIDTH-1:0]           oIM_WriteData;
    logic [I_IMM_WIDTH-1:0]       oIM_WriteData_IMM;

    modport master (
        output iS_Data, iS_Valid,
        input  oS_Ready, oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM
    );

    modport slave (
        input  iS_Data, iS_Valid,
        output oS_Ready, oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM
    );
endinterface

// File: rtl/cgra_im_loader_fsm.sv
// Loader sequencing: state register, remaining-instruction counter and
// per-word action strobes. Checksum state only with IM_LOADER_CHECKSUM_EN.
module cgra_im_loader_fsm
    import cgra_im_loader_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int NUM_ID  = 10,
    parameter int NUM_IMM = 3
) (
    input  logic                iClk,
    input  logic                iReset_n,
    input  logic                iAbort,
    input  logic                iValid,
    input  logic [TARGET_W-1:0] iTarget,
    input  logic [CNT_W-1:0]    iCount,
    output state_t              oState,
    output logic                oReady,
    output logic                oHdr0,
    output logic                oHdr1,
    output logic                oDecWrite,
    output logic                oLoCapture,
`ifdef IM_LOADER_CHECKSUM_EN
    output logic                oCsumAccept,
`endif
    output logic                oImmWrite
);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t           state, stateNext;
    logic [CNT_W-1:0] remaining, remainingNext;
    logic             isImm, readyEn, accept, targetIsImm;

    assign oState      = state;
    assign oReady      = readyEn && (state != S_DONE);
    assign accept      = iValid && oReady && !iAbort;
    assign targetIsImm = (iTarget >= TARGET_W'(NUM_ID)) && (iTarget < TARGET_W'(NUM_ID + NUM_IMM));

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            isImm     <= 1'b0;
            readyEn   <= 1'b0;
        end else begin
            state     <= stateNext;
            remaining <= remainingNext;
            readyEn   <= 1'b1;
            if (oHdr0) isImm <= targetIsImm;
        end
    end

    // Invalid targets are framed like decoder targets so the stream stays aligned.
    always_comb begin
        stateNext     = state;
        remainingNext = remaining;
        oHdr0         = 1'b0;
        oHdr1         = 1'b0;
        oDecWrite     = 1'b0;
        oLoCapture    = 1'b0;
        oImmWrite     = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        oCsumAccept   = 1'b0;
`endif
        if (iAbort) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    oHdr0         = 1'b1;
                    remainingNext = iCount;
                    stateNext     = S_ADDR;
                end
                S_ADDR: if (accept) begin
                    oHdr1     = 1'b1;
                    stateNext = (remaining == '0) ? S_DONE : S_DATA_LO;
                end
                S_DATA_LO: if (accept) begin
                    if (isImm) begin
                        oLoCapture = 1'b1;
                        stateNext  = S_DATA_HI;
                    end else begin
                        oDecWrite     = 1'b1;
                        remainingNext = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) stateNext = S_AFTER_DATA;
                    end
                end
                S_DATA_HI: if (accept) begin
                    oImmWrite     = 1'b1;
                    remainingNext = remaining - CNT_W'(1);
                    stateNext     = (remaining == CNT_W'(1)) ? S_AFTER_DATA : S_DATA_LO;
                end
`ifdef IM_LOADER_CHECKSUM_EN
                S_CSUM: if (accept) begin
                    oCsumAccept = 1'b1;
                    stateNext   = S_DONE;
                end
`endif
                S_DONE:  stateNext = S_IDLE;
                default: stateNext = S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cgra_im_loader.sv
// Stream-to-instruction-memory loader: header decode, address counter, data
// assembly and registered write bus. Optional IM_LOADER_CHECKSUM_EN checksum.
module cgra_im_loader
    import cgra_im_loader_pkg::*;
#(
    parameter int D_WIDTH           = 32,
    parameter int I_WIDTH           = 12,
    parameter int I_IMM_WIDTH       = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 10,
    parameter int NUM_IMM           = 3
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iAbort,
    cgra_im_loader_if.slave       bus,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError
);

    localparam int NUM_MEM = NUM_ID + NUM_IMM;
    localparam int CNT_W   = D_WIDTH - COUNT_LSB;
    localparam int HI_W    = immHiWidth(I_IMM_WIDTH, D_WIDTH);

    state_t                       state;
    logic                         hdr0, hdr1, decWrite, loCapture, immWrite;
    logic [TARGET_W-1:0]          target;
    logic [IM_MEM_ADDR_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0]           loWord;
    logic [NUM_MEM-1:0]           writeEnable;
    logic [IM_MEM_ADDR_WIDTH-1:0] writeAddress;
    logic [I_WIDTH-1:0]           writeData;
    logic [I_IMM_WIDTH-1:0]       writeDataImm;
    logic                         doneReg, errorReg, targetValid, hdrTargetValid;
`ifdef IM_LOADER_CHECKSUM_EN
    logic                         csumAccept;
    logic [D_WIDTH-1:0]           csum;
`endif

    cgra_im_loader_fsm #(
        .CNT_W   (CNT_W),
        .NUM_ID  (NUM_ID),
        .NUM_IMM (NUM_IMM)
    ) uFsm (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .iAbort      (iAbort),
        .iValid      (bus.iS_Valid),
        .iTarget     (bus.iS_Data[TARGET_LSB +: TARGET_W]),
        .iCount      (bus.iS_Data[COUNT_LSB +: CNT_W]),
        .oState      (state),
        .oReady      (bus.oS_Ready),
        .oHdr0       (hdr0),
        .oHdr1       (hdr1),
        .oDecWrite   (decWrite),
        .oLoCapture  (loCapture),
`ifdef IM_LOADER_CHECKSUM_EN
        .oCsumAccept (csumAccept),
`endif
        .oImmWrite   (immWrite)
    );

    assign targetValid    = target < TARGET_W'(NUM_MEM);
    assign hdrTargetValid = bus.iS_Data[TARGET_LSB +: TARGET_W] < TARGET_W'(NUM_MEM);

    assign bus.oIM_WriteEnable   = writeEnable;
    assign bus.oIM_WriteAddress  = writeAddress;
    assign bus.oIM_WriteData     = writeData;
    assign bus.oIM_WriteData_IMM = writeDataImm;
    assign oBusy  = (state != S_IDLE);
    assign oDone  = doneReg;
    assign oError = errorReg;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            target       <= '0;
            addr         <= '0;
            loWord       <= '0;
            writeEnable  <= '0;
            writeAddress <= '0;
            writeData    <= '0;
            writeDataImm <= '0;
            doneReg      <= 1'b0;
            errorReg     <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            writeEnable <= '0;
            doneReg     <= (state == S_DONE) && !iAbort;
            if (hdr0) begin
                target   <= bus.iS_Data[TARGET_LSB +: TARGET_W];
                errorReg <= !hdrTargetValid;
            end
            if (hdr1)      addr   <= bus.iS_Data[IM_MEM_ADDR_WIDTH-1:0];
            if (loCapture) loWord <= bus.iS_Data;
            // Address advances even for an invalid target; only the bus stays quiet.
            if (decWrite || immWrite) begin
                addr <= addr + IM_MEM_ADDR_WIDTH'(1);
                if (targetValid) begin
                    for (int unsigned i = 0; i < NUM_MEM; i++)
                        writeEnable[i] <= (target == TARGET_W'(i));
                    writeAddress <= addr;
                    if (decWrite) writeData    <= bus.iS_Data[I_WIDTH-1:0];
                    else          writeDataImm <= {bus.iS_Data[HI_W-1:0], loWord};
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            if (hdr1)
                csum <= '0;
            else if (decWrite || loCapture || immWrite)
                csum <= csum ^ bus.iS_Data;
            if (csumAccept && (bus.iS_Data != csum)) errorReg <= 1'b1;
`endif
        end
    end

endmodule
